// File: rtl/thunderbird_pkg.sv
// Shared definitions for the thunderbird rear-lamp controller:
// FSM state encoding and the lamp chase patterns.
package thunderbird_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    L1   = 4'd1,
    L2   = 4'd2,
    L3   = 4'd3,
    R1   = 4'd4,
    R2   = 4'd5,
    R3   = 4'd6,
    HON  = 4'd7,
    HOFF = 4'd8,
    GAP  = 4'd9
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

endpackage

// File: rtl/thunderbird_ctrl_if.sv
// Driver request / lamp output bundle between the dashboard side (master)
// and the lamp controller (slave).
interface thunderbird_ctrl_if;

  logic       left;
  logic       right;
  logic       hazard;
  logic [2:0] l;
  logic [2:0] r;
  logic       busy;

  modport master (
    output left, right, hazard,
    input  l, r, busy
  );

  modport slave (
    input  left, right, hazard,
    output l, r, busy
  );

endinterface

// File: rtl/thunderbird_ctrl_step_prescaler.sv
// Animation step prescaler: counts 0..TICK_DIV-1 and flags the last cycle
// of each step. The FSM clears it on every state change so that each
// step starts from a fresh count.
module step_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Step counter: restart on clear or at the end of a step, else advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/thunderbird_ctrl.sv
// Turn-signal / hazard controller for the six-lamp rear cluster.
// Moore FSM: lamps and busy are decoded from the state register only,
// each non-idle state lasts one prescaler step.
module thunderbird_ctrl
  import thunderbird_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  thunderbird_ctrl_if.slave  bus
);

  state_t     state;
  state_t     state_next;
  logic       tick;
  logic       clr;
  logic       haz_req;
  logic       left_req;
  logic       right_req;
  logic [2:0] lamp_l;
  logic [2:0] lamp_r;

  // Both turn levers at once are treated as a hazard request.
  assign haz_req   = bus.hazard | (bus.left & bus.right);
  assign left_req  = bus.left  & ~bus.right & ~bus.hazard;
  assign right_req = bus.right & ~bus.left  & ~bus.hazard;

  step_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // State register; reset aborts any running sequence immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: idle reacts at once, running states advance on tick,
  // hazard pre-empts a turn at its next step boundary.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (haz_req) begin
          state_next = HON;
        end else if (left_req) begin
          state_next = L1;
        end else if (right_req) begin
          state_next = R1;
        end
      end
      L1:   if (tick) state_next = haz_req ? HON : L2;
      L2:   if (tick) state_next = haz_req ? HON : L3;
      L3:   if (tick) state_next = haz_req ? HON : GAP;
      R1:   if (tick) state_next = haz_req ? HON : R2;
      R2:   if (tick) state_next = haz_req ? HON : R3;
      R3:   if (tick) state_next = haz_req ? HON : GAP;
      GAP:  if (tick) state_next = IDLE;
      HON:  if (tick) state_next = HOFF;
      HOFF: if (tick) state_next = haz_req ? HON : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Prescaler is held clear in idle and restarted on every state change.
  always_comb begin
    clr = 1'b0;
    if ((state_next != state) || (state == IDLE)) begin
      clr = 1'b1;
    end
  end

  // Lamp decode from the registered state only.
  always_comb begin
    lamp_l = LAMP_OFF;
    lamp_r = LAMP_OFF;
    case (state)
      L1:  lamp_l = LAMP_1;
      L2:  lamp_l = LAMP_2;
      L3:  lamp_l = LAMP_3;
      R1:  lamp_r = LAMP_1;
      R2:  lamp_r = LAMP_2;
      R3:  lamp_r = LAMP_3;
      HON: begin
        lamp_l = LAMP_3;
        lamp_r = LAMP_3;
      end
      default: begin
        lamp_l = LAMP_OFF;
        lamp_r = LAMP_OFF;
      end
    endcase
  end

  assign bus.l    = lamp_l;
  assign bus.r    = lamp_r;
  assign bus.busy = (state != IDLE);

endmodule
